// File: rtl/reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl
//
// Purpose:
//   Owns the register file write port and read port 1. It arbitrates the write
//   port between three sources:
//     * a post-reset clear sequencer that writes CLEAR_VALUE into R0..R30,
//     * the pipeline write-back stage (combinational pass-through),
//     * a debug access port using a 4-phase req/ack handshake.
//   While the controller owns the register file it raises cpu_hold to freeze
//   the pipeline.
//
// Configuration macro:
//   RF_CLEAR_EN - defined: reset enters the CLEAR sequence (R0..R30 zeroed,
//                 cpu_hold and clear_busy high while clearing).
//                 undefined: reset goes straight to IDLE, clear_busy is tied
//                 low and cpu_hold resets low.
//
// Parameters:
//   HOLD_CYCLES  cycles of cpu_hold before a debug access so in-flight
//                exec/mem/wb writes retire (legal range 1..7)
//   CLEAR_VALUE  value written to every cleared register
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   wb_we/wb_wa/wb_wd        write-back stage write request
//   dec_ra1                  decode-stage read address 1
//   dbg_req/dbg_we/dbg_addr/dbg_wdata   debug request and its payload
//   dbg_ack/dbg_rdata        debug acknowledge and read data
//   rf_rd1                   reg_file read data 1
//   rf_ra1                   reg_file read address 1
//   rf_we/rf_wa/rf_wd        reg_file write port
//   cpu_hold                 pipeline hold request
//   clear_busy               clear sequence in progress
//   err_wb_drop              sticky flag: a write-back write was dropped
// -----------------------------------------------------------------------------

`default_nettype none

module reg_file_ctrl #(
    parameter int          HOLD_CYCLES = 3,
    parameter logic [31:0] CLEAR_VALUE = 32'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,

    input  logic [4:0]  dec_ra1,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,

    input  logic [31:0] rf_rd1,
    output logic [4:0]  rf_ra1,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,

    output logic        cpu_hold,
    output logic        clear_busy,
    output logic        err_wb_drop
);

    // -------------------------------------------------------------------------
    // Debug handshake (4-phase):
    //   1. requester raises dbg_req with dbg_we/dbg_addr/dbg_wdata valid;
    //      the payload is captured on the first IDLE cycle that sees dbg_req,
    //      so the requester may change it afterwards;
    //   2. controller raises dbg_ack once the access is done (dbg_rdata is
    //      valid while dbg_ack=1 for reads);
    //   3. requester drops dbg_req;
    //   4. controller drops dbg_ack on the following cycle and returns to IDLE.
    //   A request seen while clearing stays pending until IDLE.
    // -------------------------------------------------------------------------

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

`ifdef RF_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    localparam logic [4:0] LAST_CLEAR_ADDR = 5'd30;
    localparam logic [4:0] ZERO_REG_ADDR   = 5'd31;
    // DRAIN is entered with HOLD_CYCLES-1 and leaves when the count is 0,
    // giving exactly HOLD_CYCLES drain cycles.
    localparam logic [4:0] HOLD_LOAD       = 5'(HOLD_CYCLES - 1);

    // FSM state is kept in a named signal so checkers can bind to it.
    state_t      state;
    state_t      state_next;

    // Shared counter: clear address in CLEAR, drain down-counter in DRAIN.
    logic [4:0]  cnt;
    logic [4:0]  cnt_next;

    // Captured debug request payload.
    logic        cap_we;
    logic [4:0]  cap_addr;
    logic [31:0] cap_wdata;

    // Single-cycle strobes from the combinational block.
    logic        dbg_capture;
    logic        rd_capture;
    logic        wb_drop;

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        rf_we       = 1'b0;
        rf_wa       = wb_wa;
        rf_wd       = wb_wd;
        rf_ra1      = dec_ra1;
        cpu_hold    = 1'b1;
        dbg_ack     = 1'b0;
        dbg_capture = 1'b0;
        rd_capture  = 1'b0;
        wb_drop     = 1'b0;

        case (state)
            ST_CLEAR: begin
                // The clear write owns the port; a concurrent wb write is lost.
                rf_we    = 1'b1;
                rf_wa    = cnt;
                rf_wd    = CLEAR_VALUE;
                wb_drop  = wb_we;
                if (cnt == LAST_CLEAR_ADDR) begin
                    state_next = ST_IDLE;
                    cnt_next   = 5'd0;
                end else begin
                    cnt_next   = cnt + 5'd1;
                end
            end

            ST_IDLE: begin
                cpu_hold = 1'b0;
                rf_we    = wb_we;
                if (dbg_req) begin
                    dbg_capture = 1'b1;
                    cnt_next    = HOLD_LOAD;
                    state_next  = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Writes already in flight in the pipeline still retire here.
                rf_we = wb_we;
                if (cnt == 5'd0) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next   = cnt - 5'd1;
                end
            end

            ST_ACCESS: begin
                wb_drop = wb_we;
                if (cap_we) begin
                    // R31 is the hardwired zero register: never write it.
                    rf_we = (cap_addr != ZERO_REG_ADDR);
                    rf_wa = cap_addr;
                    rf_wd = cap_wdata;
                end else begin
                    rf_ra1     = cap_addr;
                    rd_capture = 1'b1;
                end
                state_next = ST_ACK;
            end

            ST_ACK: begin
                dbg_ack = 1'b1;
                if (!dbg_req) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = RESET_STATE;
                cnt_next   = 5'd0;
            end
        endcase
    end

`ifdef RF_CLEAR_EN
    assign clear_busy = (state == ST_CLEAR);
`else
    assign clear_busy = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Debug payload capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_addr  <= 5'd0;
            cap_wdata <= 32'd0;
        end else if (dbg_capture) begin
            cap_we    <= dbg_we;
            cap_addr  <= dbg_addr;
            cap_wdata <= dbg_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Debug read data: loaded only by a debug read, held otherwise
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata <= 32'd0;
        end else if (rd_capture) begin
            dbg_rdata <= rf_rd1;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky dropped-write flag, cleared only by reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_wb_drop <= 1'b0;
        end else if (wb_drop) begin
            err_wb_drop <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_ctrl
//
// Self-checking bench for reg_file_ctrl. A simple register file lives in the
// bench (R31 reads as zero) and is driven by the DUT write port. A reference
// array tracks what every register must hold; debug read data is queued in
// exp_q when a read is issued and compared when the ack is seen.
// Works with or without RF_CLEAR_EN defined.
// -----------------------------------------------------------------------------

module tb_reg_file_ctrl;

  localparam int H = 3;

`ifdef RF_CLEAR_EN
  localparam logic EXP_HOLD_RST = 1'b1;
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_HOLD_RST = 1'b0;
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        wb_we = 1'b0;
  logic [4:0]  wb_wa = 5'd0;
  logic [31:0] wb_wd = 32'd0;
  logic [4:0]  dec_ra1 = 5'd0;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_wdata = 32'd0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [31:0] rf_rd1;
  logic [4:0]  rf_ra1;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        cpu_hold;
  logic        clear_busy;
  logic        err_wb_drop;

  reg_file_ctrl #(
    .HOLD_CYCLES (H),
    .CLEAR_VALUE (32'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we       (wb_we),
    .wb_wa       (wb_wa),
    .wb_wd       (wb_wd),
    .dec_ra1     (dec_ra1),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .rf_rd1      (rf_rd1),
    .rf_ra1      (rf_ra1),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .cpu_hold    (cpu_hold),
    .clear_busy  (clear_busy),
    .err_wb_drop (err_wb_drop)
  );

  // ---------------------------------------------------------------------------
  // Register file attached to the DUT (bench-side fill port used during reset)
  // ---------------------------------------------------------------------------
  logic [31:0] rf_mem [32];
  logic        fill_en = 1'b0;
  logic [4:0]  fill_idx = 5'd0;
  logic [31:0] fill_val = 32'd0;

  always @(posedge clk) begin
    if (fill_en) rf_mem[fill_idx] <= fill_val;
    else if (rf_we && rf_wa != 5'd31) rf_mem[rf_wa] <= rf_wd;
  end

  assign rf_rd1 = (rf_ra1 == 5'd31) ? 32'd0 : rf_mem[rf_ra1];

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] ref_rf [32];
  logic        exp_err = 1'b0;
  logic [31:0] last_rd = 32'd0;
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic wb_idle(input logic [4:0] addr, input logic [31:0] data);
    logic [4:0] ra;
    ra = 5'($urandom_range(0, 31));
    wb_we = 1'b1; wb_wa = addr; wb_wd = data; dec_ra1 = ra;
    @(negedge clk);
    check("idle_wb_we", rf_we, 1'b1);
    check("idle_wb_wa", rf_wa, addr);
    check("idle_wb_wd", rf_wd, data);
    check("idle_ra1", rf_ra1, ra);
    check("idle_hold", cpu_hold, 1'b0);
    check("idle_busy", clear_busy, 1'b0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    if (addr != 5'd31) ref_rf[addr] = data;
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         input int extra, input logic inject);
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_we;
    ra = 5'($urandom_range(0, 31));
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    wb_we = 1'b0; dec_ra1 = ra;
    @(negedge clk);
    check("req_idle_hold", cpu_hold, 1'b0);
    check("req_idle_busy", clear_busy, 1'b0);
    check("req_idle_ra1", rf_ra1, ra);
    check("req_idle_ack", dbg_ack, 1'b0);
    @(posedge clk); #1;
    // Payload has been captured; scramble it to prove it is not reused live.
    dbg_we = ~we; dbg_addr = ~addr; dbg_wdata = $urandom;
    for (int k = 0; k < H; k++) begin
      wb_we = 1'($urandom_range(0, 1));
      wb_wa = 5'($urandom_range(0, 31));
      wb_wd = $urandom;
      @(negedge clk);
      check("drain_hold", cpu_hold, 1'b1);
      check("drain_ack", dbg_ack, 1'b0);
      check("drain_we", rf_we, wb_we);
      if (wb_we) begin
        check("drain_wa", rf_wa, wb_wa);
        check("drain_wd", rf_wd, wb_wd);
        if (wb_wa != 5'd31) ref_rf[wb_wa] = wb_wd;
      end
      @(posedge clk); #1;
    end
    wb_we = inject;
    wb_wa = 5'($urandom_range(0, 31));
    wb_wd = $urandom;
    if (inject) exp_err = 1'b1;
    @(negedge clk);
    check("access_hold", cpu_hold, 1'b1);
    check("access_ack", dbg_ack, 1'b0);
    if (we) begin
      exp_we = (addr != 5'd31);
      check("access_we", rf_we, exp_we);
      if (exp_we) begin
        check("access_wa", rf_wa, addr);
        check("access_wd", rf_wd, wdata);
        ref_rf[addr] = wdata;
      end
    end else begin
      check("access_rd_we", rf_we, 1'b0);
      check("access_ra1", rf_ra1, addr);
      exp_q.push_back(ref_rf[addr]);
    end
    @(posedge clk); #1;
    wb_we = 1'b0;
    for (int j = 0; j <= extra; j++) begin
      @(negedge clk);
      check("ack_high", dbg_ack, 1'b1);
      check("ack_hold", cpu_hold, 1'b1);
      if (!we) check("ack_rdata", dbg_rdata, exp_q[0]);
      else     check("ack_rdata_keep", dbg_rdata, last_rd);
      @(posedge clk); #1;
    end
    dbg_req = 1'b0;
    @(negedge clk);
    check("ack_until_drop", dbg_ack, 1'b1);
    @(posedge clk); #1;
    if (!we) begin
      exp_rd = exp_q.pop_front();
      last_rd = exp_rd;
    end
    @(negedge clk);
    check("post_ack_low", dbg_ack, 1'b0);
    check("post_hold_low", cpu_hold, 1'b0);
    check("post_rdata_keep", dbg_rdata, last_rd);
    check("err_wb_drop", err_wb_drop, exp_err);
    @(posedge clk); #1;
  endtask

`ifdef RF_CLEAR_EN
  task automatic run_clear(input int inject_at);
    for (int i = 0; i < 31; i++) begin
      wb_we = (i == inject_at);
      wb_wa = 5'($urandom_range(0, 31));
      wb_wd = $urandom;
      @(negedge clk);
      check("clear_we", rf_we, 1'b1);
      check("clear_wa", rf_wa, 32'(i));
      check("clear_wd", rf_wd, 32'd0);
      check("clear_busy", clear_busy, 1'b1);
      check("clear_hold", cpu_hold, 1'b1);
      check("clear_ack", dbg_ack, 1'b0);
      @(posedge clk); #1;
    end
    wb_we = 1'b0;
    for (int i = 0; i < 31; i++) ref_rf[i] = 32'd0;
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] v;
    logic        w;
    logic [4:0]  a;

    // Fill the register file with random contents while reset is held.
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      v = (i == 31) ? 32'd0 : $urandom;
      fill_en = 1'b1; fill_idx = 5'(i); fill_val = v;
      ref_rf[i] = v;
    end
    @(posedge clk); #1;
    fill_en = 1'b0;

    @(negedge clk);
    check("rst_ack", dbg_ack, 1'b0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_hold", cpu_hold, EXP_HOLD_RST);
    check("rst_busy", clear_busy, EXP_BUSY_RST);
    check("rst_err", err_wb_drop, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef RF_CLEAR_EN
    run_clear(10);
    exp_err = 1'b1;
`endif
    check("err_after_clear", err_wb_drop, exp_err);

    // Directed cases.
    dbg_txn(1'b0, 5'd5, 32'd0, 0, 1'b0);
    wb_idle(5'd7, 32'hDEADBEEF);
    dbg_txn(1'b1, 5'd3, 32'h12345678, 0, 1'b0);
    dbg_txn(1'b0, 5'd3, 32'd0, 1, 1'b0);
    dbg_txn(1'b0, 5'd7, 32'd0, 0, 1'b0);
    dbg_txn(1'b1, 5'd31, 32'hCAFEF00D, 0, 1'b0);
    dbg_txn(1'b0, 5'd31, 32'd0, 2, 1'b0);

    // Asynchronous reset in the middle of DRAIN; the request stays asserted.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hA5A50009;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_hold", cpu_hold, EXP_HOLD_RST);
    check("mid_rst_ack", dbg_ack, 1'b0);
    check("mid_rst_err", err_wb_drop, 1'b0);
    check("mid_rst_rdata", dbg_rdata, 32'd0);
    exp_err = 1'b0;
    last_rd = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    dbg_we = 1'b0;
`ifdef RF_CLEAR_EN
    run_clear(-1);
`endif
    // The abandoned write must not have landed.
    dbg_txn(1'b0, 5'd9, 32'd0, 0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom_range(0, 31));
      v = $urandom;
      w = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       wb_idle(a, v);
        1:       dbg_txn(1'b1, a, v, int'($urandom_range(0, 2)), w);
        default: dbg_txn(1'b0, a, v, int'($urandom_range(0, 2)), w);
      endcase
    end

    check("final_err", err_wb_drop, exp_err);
    for (int i = 0; i < 31; i++) begin
      check($sformatf("final_r%0d", i), rf_mem[i], ref_rf[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
